// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the output burst FIFO.
//   fifo_state_t : FSM states FILL, LOAD, DRAIN, CLEAR
//   DATA_W_DEF   : default word width
//   ptr_w/cnt_w  : pointer and word-count widths for a given depth
package fifo_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } fifo_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array, synchronous write, combinational read.
//   clk      : clock
//   wr_en    : write strobe, stores wr_data at wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : mem[rd_addr], combinational
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_out.sv
// fifo_out: output-side burst buffer. Collects BURST words from the core,
// then presents them one at a time to the reader via dout/dout_valid/rd_en.
//   clk        : clock
//   rst        : synchronous active-high reset
//   wr_en/din  : core write strobe and data
//   full       : write refused this cycle
//   empty      : no words stored
//   word_count : words currently stored
//   rd_en      : reader pop request
//   dout       : registered read data
//   dout_valid : dout holds an unread burst word
//   burst_done : one-cycle pulse after the final word is popped
//
// state | meaning
// FILL  | accepting core writes until BURST words are stored
// LOAD  | one cycle: first word moved into the output register
// DRAIN | reader pops words; writes refused
// CLEAR | one cycle: pointers and count reset before next burst
module fifo_out
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int BURST  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic                       burst_done
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  fifo_state_t       state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_accept, pop, pop_last;

  assign full  = (state != FILL) || (word_count == CNT_W'(DEPTH));
  assign empty = (word_count == '0);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // No writes land during DRAIN, so the count runs BURST..1 there and
  // count == 1 identifies the final word.
  always_comb begin
    state_nxt = state;
    wr_accept = wr_en && !full;
    pop       = 1'b0;
    pop_last  = 1'b0;
    rd_addr   = rd_ptr;
    case (state)
      FILL: begin
        if (wr_accept && (word_count == CNT_W'(BURST - 1))) state_nxt = LOAD;
      end
      LOAD: state_nxt = DRAIN;
      DRAIN: begin
        pop      = rd_en && dout_valid;
        pop_last = pop && (word_count == CNT_W'(1));
        // Look one word ahead so a pop refills dout with the next word.
        rd_addr  = rd_ptr + 1'b1;
        if (pop_last) state_nxt = CLEAR;
      end
      CLEAR: state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (wr_accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      case (state)
        LOAD: begin
          dout       <= rd_data;
          dout_valid <= 1'b1;
        end
        DRAIN: begin
          if (pop) begin
            word_count <= word_count - 1'b1;
            if (pop_last) begin
              dout       <= '0;
              dout_valid <= 1'b0;
              burst_done <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              dout   <= rd_data;
            end
          end
        end
        CLEAR: begin
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          word_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_out.sv
// tb_fifo_out: directed self-checking bench for fifo_out (DEPTH=4, BURST=4).
module tb_fifo_out;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int BURST  = 4;

  typedef logic [31:0] burst_t [4];

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              full;
  logic              empty;
  logic [2:0]        word_count;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              burst_done;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  fifo_out #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BURST  (BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .din        (din),
    .full       (full),
    .empty      (empty),
    .word_count (word_count),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .burst_done (burst_done)
  );

  always @(posedge clk) begin
    if (burst_done === 1'b1) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input burst_t b);
    for (int i = 0; i < BURST; i++) begin
      wr_en = 1'b1;
      din   = b[i];
      step();
      chk("wr_count", 32'(word_count), 32'(i + 1));
      chk("wr_full", 32'(full), 32'(i == BURST - 1));
      chk("wr_no_valid", 32'(dout_valid), 32'd0);
    end
    wr_en = 1'b0;
  endtask

  // Entry: dout already shows b[0] with dout_valid high.
  task automatic drain_tail(input burst_t b);
    rd_en = 1'b1;
    for (int k = 1; k < BURST; k++) begin
      step();
      chk("drain_dout", dout, b[k]);
      chk("drain_valid", 32'(dout_valid), 32'd1);
      chk("drain_count", 32'(word_count), 32'(BURST - k));
      chk("drain_done_low", 32'(burst_done), 32'd0);
    end
    step();
    chk("last_valid", 32'(dout_valid), 32'd0);
    chk("last_dout", dout, 32'd0);
    chk("last_done", 32'(burst_done), 32'd1);
    chk("last_full", 32'(full), 32'd1);
    step();
    chk("clear_done", 32'(burst_done), 32'd0);
    chk("clear_full", 32'(full), 32'd0);
    chk("clear_count", 32'(word_count), 32'd0);
    chk("clear_empty", 32'(empty), 32'd1);
  endtask

  task automatic run_burst(input burst_t b);
    write_burst(b);
    step();
    chk("first_valid", 32'(dout_valid), 32'd1);
    chk("first_dout", dout, b[0]);
    drain_tail(b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_t b;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_done", 32'(burst_done), 32'd0);

    // Burst with rd_en held high throughout.
    b = '{32'h11, 32'h22, 32'h33, 32'h44};
    rd_en = 1'b1;
    run_burst(b);

    // Reader stalls 5 cycles after dout_valid rises.
    rd_en = 1'b0;
    write_burst(b);
    step();
    chk("stall_valid", 32'(dout_valid), 32'd1);
    chk("stall_dout0", dout, 32'h11);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_dout", dout, 32'h11);
      chk("stall_count", 32'(word_count), 32'd4);
      chk("stall_valid_hold", 32'(dout_valid), 32'd1);
    end
    drain_tail(b);

    // Writes held with 0xDEAD during LOAD/DRAIN/CLEAR are refused.
    b = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    rd_en = 1'b1;
    wr_en = 1'b1; din = b[0]; step();
    din = b[1]; step();
    wr_en = 1'b0; step();
    chk("part_count", 32'(word_count), 32'd2);
    chk("part_full", 32'(full), 32'd0);
    wr_en = 1'b1; din = b[2]; step();
    din = b[3]; step();
    chk("part_full4", 32'(full), 32'd1);
    din = 32'hDEAD;
    step();
    chk("dead_first_dout", dout, 32'hC0);
    chk("dead_full", 32'(full), 32'd1);
    drain_tail(b);
    wr_en = 1'b0;
    b = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    run_burst(b);

    // Reset after two pops discards the partial burst.
    b = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    rd_en = 1'b0;
    write_burst(b);
    step();
    chk("a_dout0", dout, 32'hA0);
    rd_en = 1'b1;
    step();
    chk("a_dout1", dout, 32'hA1);
    step();
    chk("a_dout2", dout, 32'hA2);
    chk("a_count", 32'(word_count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_dout", dout, 32'd0);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_count", 32'(word_count), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    b = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    run_burst(b);

    // rd_en in FILL with 3 words stored is ignored.
    b = '{32'h51, 32'h52, 32'h53, 32'h54};
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = b[i]; step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    chk("fill_rd_count", 32'(word_count), 32'd3);
    chk("fill_rd_valid", 32'(dout_valid), 32'd0);
    rd_en = 1'b0;
    step();
    chk("fill_rd_count2", 32'(word_count), 32'd3);
    wr_en = 1'b1; din = b[3]; step();
    wr_en = 1'b0;
    chk("fill_last_full", 32'(full), 32'd1);
    step();
    chk("fill_dout0", dout, 32'h51);
    drain_tail(b);

    // Three back-to-back bursts with continuous traffic.
    rd_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < BURST; i++) b[i] = 32'h1000 * (r + 1) + 32'(i);
      run_burst(b);
    end

    step();
    chk("burst_done_total", 32'(n_done), 32'd9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
